block_lock: RTL and testbench

BLOCK_LOCK -- requirements
Module: block_lock

---
 rtl/block_lock_pkg.sv | 17 +
 rtl/hdr_argmax.sv | 43 ++++
 rtl/block_lock.sv | 149 ++++++++++++++
 tb/tb_block_lock.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/block_lock_pkg.sv
// Shared header encodings, lock FSM states and header-validity helper
// for the block_lock slice.
package block_lock_pkg;

  localparam logic [1:0] HDR_DATA = 2'b01;
  localparam logic [1:0] HDR_CMD  = 2'b10;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  function automatic logic hdr_valid(input logic [1:0] hdr);
    return (hdr == HDR_DATA) || (hdr == HDR_CMD);
  endfunction

endpackage

// File: rtl/hdr_argmax.sv
// Registered argmax over N packed counters; ties resolve to the lowest index.
// clr_i zeroes the captured result on the same edge the counters are cleared.
module hdr_argmax #(
  parameter int N     = 66,
  parameter int CNT_W = 6,
  localparam int OFF_W = $clog2(N)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic [N*CNT_W-1:0] cnt_i,
  output logic [CNT_W-1:0]   best_cnt_o,
  output logic [OFF_W-1:0]   best_off_o
);

  logic [CNT_W-1:0] max_cnt;
  logic [OFF_W-1:0] max_off;

  // NOTE: defaults first so every path assigns max_cnt/max_off and no latch is
  // inferred; blocking '=' lets each loop iteration see the running maximum.
  always_comb begin
    max_cnt = cnt_i[0 +: CNT_W];
    max_off = '0;
    for (int i = 1; i < N; i++) begin
      if (cnt_i[i*CNT_W +: CNT_W] > max_cnt) begin
        max_cnt = cnt_i[i*CNT_W +: CNT_W];
        max_off = OFF_W'(i);
      end
    end
  end

  // NOTE: sequential state uses '<=' so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      best_cnt_o <= '0;
      best_off_o <= '0;
    end else begin
      best_cnt_o <= max_cnt;
      best_off_o <= max_off;
    end
  end

endmodule

// File: rtl/block_lock.sv
// Block header lock: searches all offsets for a run of valid sync headers,
// then monitors the locked offset. Optional BLOCK_LOCK_STATS_EN adds counters.
module block_lock
  import block_lock_pkg::*;
#(
  parameter int BLOCK_W       = 66,
  parameter int CNT_W         = 6,
  parameter int LOCK_THRESH   = 32,
  parameter int WIN_BLOCKS    = 64,
  parameter int UNLOCK_THRESH = 16,
  localparam int OFF_W = $clog2(BLOCK_W)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [BLOCK_W:0]   win_i,
  input  logic               win_dv_i,
  input  logic               resync_i,
  output logic [OFF_W-1:0]   block_offset_o,
  output logic               locked_o,
  output logic               blk_dv_o,
  output logic               hdr_ok_o
`ifdef BLOCK_LOCK_STATS_EN
  ,
  output logic [15:0]        unlock_cnt_o,
  output logic [15:0]        bad_hdr_cnt_o
`endif
);

  localparam int BAD_W = $clog2(UNLOCK_THRESH + 1);
  localparam int WIN_W = $clog2(WIN_BLOCKS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  lock_state_t state_q, state_d;

  logic [CNT_W-1:0]         cnt_q [BLOCK_W];
  logic [BLOCK_W*CNT_W-1:0] cnt_flat;
  logic [CNT_W-1:0]         best_cnt;
  logic [OFF_W-1:0]         best_off;
  logic [OFF_W-1:0]         block_offset_q;
  logic [BAD_W-1:0]         bad_cnt_q, bad_nxt;
  logic [WIN_W-1:0]         win_cnt_q, win_nxt;
  logic                     blk_dv_q, hdr_ok_q;

  logic [1:0] lk_hdr;
  logic       lk_ok, dv_acc, lk_chk, lose_lock, gain_lock, clr_all;

  always_comb begin
    cnt_flat = '0;
    for (int i = 0; i < BLOCK_W; i++) cnt_flat[i*CNT_W +: CNT_W] = cnt_q[i];
  end

  hdr_argmax #(
    .N     (BLOCK_W),
    .CNT_W (CNT_W)
  ) u_argmax (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (clr_all),
    .cnt_i      (cnt_flat),
    .best_cnt_o (best_cnt),
    .best_off_o (best_off)
  );

  // Next-state and control; a resync discards any coincident window.
  always_comb begin
    dv_acc    = win_dv_i && !resync_i;
    lk_hdr    = win_i[block_offset_q +: 2];
    lk_ok     = hdr_valid(lk_hdr);
    bad_nxt   = lk_ok ? bad_cnt_q : bad_cnt_q + BAD_W'(1);
    win_nxt   = win_cnt_q + WIN_W'(1);
    lk_chk    = (state_q == LOCKED) && dv_acc;
    lose_lock = lk_chk && (bad_nxt == BAD_W'(UNLOCK_THRESH));
    gain_lock = (state_q == SEARCH) && !resync_i && (best_cnt >= CNT_W'(LOCK_THRESH));
    clr_all   = resync_i || lose_lock;
    state_d   = state_q;
    if (clr_all)        state_d = SEARCH;
    else if (gain_lock) state_d = LOCKED;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= SEARCH;
    else       state_q <= state_d;
  end

  // NOTE: the per-offset counters are flops, not RAM, and must restart from
  // zero after reset or loss of lock, so every element is explicitly cleared.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_all) begin
      for (int i = 0; i < BLOCK_W; i++) cnt_q[i] <= '0;
    end else if (dv_acc) begin
      for (int i = 0; i < BLOCK_W; i++) begin
        if (!hdr_valid(win_i[i +: 2]))  cnt_q[i] <= '0;
        else if (cnt_q[i] != CNT_MAX)   cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // The final block of a window is checked before the window restarts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      block_offset_q <= '0;
      bad_cnt_q      <= '0;
      win_cnt_q      <= '0;
      blk_dv_q       <= 1'b0;
      hdr_ok_q       <= 1'b0;
    end else begin
      blk_dv_q <= lk_chk && !lose_lock;
      hdr_ok_q <= lk_chk && !lose_lock && lk_ok;
      if (gain_lock) block_offset_q <= best_off;
      if (gain_lock || clr_all) begin
        bad_cnt_q <= '0;
        win_cnt_q <= '0;
      end else if (lk_chk) begin
        if (win_nxt == WIN_W'(WIN_BLOCKS)) begin
          bad_cnt_q <= '0;
          win_cnt_q <= '0;
        end else begin
          bad_cnt_q <= bad_nxt;
          win_cnt_q <= win_nxt;
        end
      end
    end
  end

  assign block_offset_o = block_offset_q;
  assign locked_o       = (state_q == LOCKED);
  assign blk_dv_o       = blk_dv_q;
  assign hdr_ok_o       = hdr_ok_q;

`ifdef BLOCK_LOCK_STATS_EN
  logic [15:0] unlock_cnt_q, bad_hdr_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      unlock_cnt_q  <= '0;
      bad_hdr_cnt_q <= '0;
    end else begin
      if ((state_q == LOCKED) && clr_all && (unlock_cnt_q != 16'hFFFF))
        unlock_cnt_q <= unlock_cnt_q + 16'd1;
      if (lk_chk && !lk_ok && (bad_hdr_cnt_q != 16'hFFFF))
        bad_hdr_cnt_q <= bad_hdr_cnt_q + 16'd1;
    end
  end

  assign unlock_cnt_o  = unlock_cnt_q;
  assign bad_hdr_cnt_o = bad_hdr_cnt_q;
`endif

endmodule

// File: tb/tb_block_lock.sv
// Scoreboard bench for block_lock: expected hdr_ok values are queued as
// windows are driven and popped whenever blk_dv_o pulses.
module tb_block_lock;

  localparam int BLOCK_W = 66;
  localparam int OFF_W   = $clog2(BLOCK_W);

  logic               clk = 1'b0;
  logic               rst_i;
  logic [BLOCK_W:0]   win_i;
  logic               win_dv_i;
  logic               resync_i;
  logic [OFF_W-1:0]   block_offset_o;
  logic               locked_o;
  logic               blk_dv_o;
  logic               hdr_ok_o;
`ifdef BLOCK_LOCK_STATS_EN
  logic [15:0]        unlock_cnt_o;
  logic [15:0]        bad_hdr_cnt_o;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int ok0_seen = 0;
  bit exp_q[$];

  block_lock dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .win_i          (win_i),
    .win_dv_i       (win_dv_i),
    .resync_i       (resync_i),
    .block_offset_o (block_offset_o),
    .locked_o       (locked_o),
    .blk_dv_o       (blk_dv_o),
    .hdr_ok_o       (hdr_ok_o)
`ifdef BLOCK_LOCK_STATS_EN
    ,
    .unlock_cnt_o   (unlock_cnt_o),
    .bad_hdr_cnt_o  (bad_hdr_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Random window with a forced header at off_a (and off_b when >= 0).
  function automatic logic [BLOCK_W:0] mk_win(input int off_a, input int off_b, input bit good);
    logic [BLOCK_W:0] w;
    logic [1:0]       h;
    for (int i = 0; i <= BLOCK_W; i++) w[i] = 1'($urandom_range(0, 1));
    if (good) h = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    else      h = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
    w[off_a +: 2] = h;
    if (off_b >= 0) w[off_b +: 2] = h;
    return w;
  endfunction

  task automatic send(input logic [BLOCK_W:0] w, input bit exp_pulse, input bit exp_ok);
    win_i    = w;
    win_dv_i = 1'b1;
    if (exp_pulse) exp_q.push_back(exp_ok);
    tick();
    win_dv_i = 1'b0;
  endtask

  always @(negedge clk) begin
    if (blk_dv_o) begin
      if (exp_q.size() == 0) begin
        check("blk_dv_unexpected", 32'(blk_dv_o), 32'd0);
      end else begin
        check("hdr_ok", 32'(hdr_ok_o), 32'(exp_q.pop_front()));
        if (!hdr_ok_o) ok0_seen++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst_i    = 1'b1;
    win_i    = '0;
    win_dv_i = 1'b0;
    resync_i = 1'b0;
    tick();
    tick();
    check("rst_locked", 32'(locked_o), 32'd0);
    check("rst_blk_dv", 32'(blk_dv_o), 32'd0);
    check("rst_hdr_ok", 32'(hdr_ok_o), 32'd0);
    check("rst_offset", 32'(block_offset_o), 32'd0);
`ifdef BLOCK_LOCK_STATS_EN
    check("rst_unlock_cnt", 32'(unlock_cnt_o), 32'd0);
    check("rst_bad_hdr_cnt", 32'(bad_hdr_cnt_o), 32'd0);
`endif
    rst_i = 1'b0;

    // Valid run at offset 17: lock appears two cycles after the 32nd window.
    for (int n = 0; n < 31; n++) send(mk_win(17, -1, 1'b1), 1'b0, 1'b0);
    check("no_lock_dv31", 32'(locked_o), 32'd0);
    send(mk_win(17, -1, 1'b1), 1'b0, 1'b0);
    check("lock_dv32_c0", 32'(locked_o), 32'd0);
    tick();
    check("lock_dv32_c1", 32'(locked_o), 32'd0);
    tick();
    check("lock_dv32_c2", 32'(locked_o), 32'd1);
    check("lock_off17", 32'(block_offset_o), 32'd17);

    // Four windows with 15 bad headers each: lock holds.
    for (int w = 0; w < 4; w++) begin
      for (int j = 0; j < 64; j++) begin
        bit bad;
        bad = (j % 4 == 0) && (j < 60);
        send(mk_win(17, -1, !bad), 1'b1, !bad);
      end
    end
    tick();
    check("hold_locked", 32'(locked_o), 32'd1);
    check("hold_ok0_pulses", 32'(ok0_seen), 32'd60);
`ifdef BLOCK_LOCK_STATS_EN
    check("hold_bad_hdr_cnt", 32'(bad_hdr_cnt_o), 32'd60);
`endif

    // 16 bad headers within one window: lock drops on the 16th.
    for (int j = 0; j < 31; j++) begin
      bit bad;
      bad = (j % 2 == 0);
      send(mk_win(17, -1, !bad), j != 30, !bad);
      if (j == 29) check("unlock_pre16", 32'(locked_o), 32'd1);
    end
    check("unlock_16th", 32'(locked_o), 32'd0);
    tick();
    check("unlock_no_blk_dv", 32'(blk_dv_o), 32'd0);
`ifdef BLOCK_LOCK_STATS_EN
    check("unlock_cnt_1", 32'(unlock_cnt_o), 32'd1);
    check("unlock_bad_hdr_cnt", 32'(bad_hdr_cnt_o), 32'd76);
`endif

    // Relock needs 32 fresh windows.
    for (int n = 0; n < 31; n++) send(mk_win(17, -1, 1'b1), 1'b0, 1'b0);
    tick();
    tick();
    check("relock_31", 32'(locked_o), 32'd0);
    send(mk_win(17, -1, 1'b1), 1'b0, 1'b0);
    tick();
    tick();
    check("relock_32", 32'(locked_o), 32'd1);
    check("relock_off17", 32'(block_offset_o), 32'd17);

    // Resync with a coincident (bad) window while locked.
    resync_i = 1'b1;
    send(mk_win(17, -1, 1'b0), 1'b0, 1'b0);
    resync_i = 1'b0;
    check("resync_locked", 32'(locked_o), 32'd0);
    check("resync_blk_dv", 32'(blk_dv_o), 32'd0);
`ifdef BLOCK_LOCK_STATS_EN
    check("resync_unlock_cnt", 32'(unlock_cnt_o), 32'd2);
    check("resync_bad_hdr_cnt", 32'(bad_hdr_cnt_o), 32'd76);
`endif
    tick();
    check("resync_blk_dv_c1", 32'(blk_dv_o), 32'd0);

    // Equal runs at offsets 5 and 40: the lower offset wins.
    for (int n = 0; n < 32; n++) send(mk_win(5, 40, 1'b1), 1'b0, 1'b0);
    tick();
    tick();
    check("tie_locked", 32'(locked_o), 32'd1);
    check("tie_off5", 32'(block_offset_o), 32'd5);
    for (int n = 0; n < 3; n++) send(mk_win(5, -1, 1'b1), 1'b1, 1'b1);

    // Reset mid-lock, coincident with a window.
    rst_i = 1'b1;
    send(mk_win(5, -1, 1'b1), 1'b0, 1'b0);
    rst_i = 1'b0;
    check("mrst_locked", 32'(locked_o), 32'd0);
    check("mrst_blk_dv", 32'(blk_dv_o), 32'd0);
    check("mrst_hdr_ok", 32'(hdr_ok_o), 32'd0);
    check("mrst_offset", 32'(block_offset_o), 32'd0);
`ifdef BLOCK_LOCK_STATS_EN
    check("mrst_unlock_cnt", 32'(unlock_cnt_o), 32'd0);
    check("mrst_bad_hdr_cnt", 32'(bad_hdr_cnt_o), 32'd0);
`endif
    for (int n = 0; n < 31; n++) send(mk_win(17, -1, 1'b1), 1'b0, 1'b0);
    tick();
    tick();
    check("mrst_no_lock_31", 32'(locked_o), 32'd0);
    send(mk_win(17, -1, 1'b1), 1'b0, 1'b0);
    tick();
    tick();
    check("mrst_lock_32", 32'(locked_o), 32'd1);
    check("mrst_off17", 32'(block_offset_o), 32'd17);

    tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
